alu_issue_stage: RTL and testbench

- ID/EX issue register for the MIPS datapath.
- Each cycle it accepts one decoded-stage beat: instruction word plus register-file read data.
- It decodes opcode/funct into the 4-bit ALU operation code consumed by ALU32Bit, and selects and extends operands A and B.
- It presents the result registered to the EX stage under a valid/ready handshake, with synchronous flush for branch mispredicts.

---
 rtl/alu_issue_stage_pkg.sv | 47 ++++
 rtl/alu_op_decode.sv | 116 +++++++++++
 rtl/alu_issue_stage.sv | 81 ++++++++
 tb/tb_alu_issue_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ID/EX issue stage: ALU op codes and MIPS opcode/funct values.
package alu_issue_stage_pkg;

    // ALU operation codes understood by ALU32Bit
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    // Primary opcodes (Instruction[31:26])
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;

    // Function codes (Instruction[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of a MIPS instruction into ALU op, operands and write-back target.
module alu_op_decode
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [31:0]           instruction,
    input  logic [DATA_W-1:0]     rs_data,
    input  logic [DATA_W-1:0]     rt_data,
    output logic [3:0]            alu_control,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic                  illegal
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] shamt_zext;
    logic [DATA_W-1:0] rs_low_zext;
    logic              wr_en;

    assign op          = instruction[31:26];
    assign fn          = instruction[5:0];
    assign shamt       = instruction[10:6];
    assign imm         = instruction[15:0];
    assign imm_sext    = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext    = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_zext  = {{(DATA_W-5){1'b0}}, shamt};
    assign rs_low_zext = {{(DATA_W-5){1'b0}}, rs_data[4:0]};

    // Decode table; unmatched encodings fall through as illegal with Rs/Rt operands
    always_comb begin
        alu_control = ALU_ADD;
        a           = rs_data;
        b           = rt_data;
        wr_en       = 1'b0;
        illegal     = 1'b0;
        // R-type and SPECIAL2 write rd, everything else writes rt
        if (op == OP_RTYPE || op == OP_SPECIAL2)
            write_reg = instruction[15:11];
        else
            write_reg = instruction[20:16];

        unique case (op)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (fn)
                    FN_ADD, FN_ADDU: alu_control = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_control = ALU_SUB;
                    FN_AND:          alu_control = ALU_AND;
                    FN_OR:           alu_control = ALU_OR;
                    FN_NOR:          alu_control = ALU_NOR;
                    FN_XOR:          alu_control = ALU_XOR;
                    FN_SLT:          alu_control = ALU_SLT;
                    FN_SLL: begin
                        alu_control = ALU_SLL; a = rt_data; b = shamt_zext;
                    end
                    FN_SRL: begin
                        alu_control = ALU_SRL; a = rt_data; b = shamt_zext;
                    end
                    FN_SLLV: begin
                        alu_control = ALU_SLL; a = rt_data; b = rs_low_zext;
                    end
                    FN_SRLV: begin
                        alu_control = ALU_SRL; a = rt_data; b = rs_low_zext;
                    end
                    default: begin
                        illegal = 1'b1; wr_en = 1'b0;
                    end
                endcase
            end
            OP_SPECIAL2: begin
                if (fn == FN_MUL) begin
                    alu_control = ALU_MUL; wr_en = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_LW: begin
                b = imm_sext; wr_en = 1'b1;
            end
            OP_SW:   b = imm_sext;
            OP_SLTI: begin
                alu_control = ALU_SLT; b = imm_sext; wr_en = 1'b1;
            end
            OP_ANDI: begin
                alu_control = ALU_AND; b = imm_zext; wr_en = 1'b1;
            end
            OP_ORI: begin
                alu_control = ALU_OR; b = imm_zext; wr_en = 1'b1;
            end
            OP_XORI: begin
                alu_control = ALU_XOR; b = imm_zext; wr_en = 1'b1;
            end
            OP_LUI: begin
                alu_control = ALU_SLL;
                a           = imm_zext;
                b           = DATA_W'(16);
                wr_en       = 1'b1;
            end
            OP_BEQ, OP_BNE: alu_control = ALU_SUB;
            default:        illegal = 1'b1;
        endcase
    end

    // $zero is never a real destination
    assign reg_write = wr_en && (write_reg != '0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes one beat per cycle and holds it under valid/ready.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [31:0]           Instruction,
    input  logic [DATA_W-1:0]     RsData,
    input  logic [DATA_W-1:0]     RtData,
    input  logic                  Flush,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [3:0]            ALUControl,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic                  Illegal
);

    logic [3:0]            nxt_alu_control;
    logic [DATA_W-1:0]     nxt_a;
    logic [DATA_W-1:0]     nxt_b;
    logic                  nxt_reg_write;
    logic [REG_ADDR_W-1:0] nxt_write_reg;
    logic                  nxt_illegal;
    logic                  capture;

    alu_op_decode #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .instruction (Instruction),
        .rs_data     (RsData),
        .rt_data     (RtData),
        .alu_control (nxt_alu_control),
        .a           (nxt_a),
        .b           (nxt_b),
        .reg_write   (nxt_reg_write),
        .write_reg   (nxt_write_reg),
        .illegal     (nxt_illegal)
    );

    // No skid buffer: a slot frees up the same cycle EX takes the held beat
    assign InReady = !OutValid || OutReady;
    assign capture = InValid && InReady && !Flush;

    // Flush beats capture; capture replaces a draining beat; otherwise hold or drain
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            OutValid   <= 1'b0;
            ALUControl <= '0;
            A          <= '0;
            B          <= '0;
            RegWrite   <= 1'b0;
            WriteReg   <= '0;
            Illegal    <= 1'b0;
        end else if (Flush) begin
            // operand fields left stale; only the side-effecting flags are cleared
            OutValid <= 1'b0;
            RegWrite <= 1'b0;
            Illegal  <= 1'b0;
        end else if (capture) begin
            OutValid   <= 1'b1;
            ALUControl <= nxt_alu_control;
            A          <= nxt_a;
            B          <= nxt_b;
            RegWrite   <= nxt_reg_write;
            WriteReg   <= nxt_write_reg;
            Illegal    <= nxt_illegal;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instruction;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic        Illegal;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .InValid     (InValid),
        .InReady     (InReady),
        .Instruction (Instruction),
        .RsData      (RsData),
        .RtData      (RtData),
        .Flush       (Flush),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .ALUControl  (ALUControl),
        .A           (A),
        .B           (B),
        .RegWrite    (RegWrite),
        .WriteReg    (WriteReg),
        .Illegal     (Illegal)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        InValid = 1'b1; Instruction = ins; RsData = rs; RtData = rt;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] op, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [4:0] wr, input logic rw,
                           input logic il);
        chk({tag, ".valid"},   32'(OutValid),   32'd1);
        chk({tag, ".op"},      32'(ALUControl), 32'(op));
        chk({tag, ".a"},       A,               ea);
        chk({tag, ".b"},       B,               eb);
        chk({tag, ".wreg"},    32'(WriteReg),   32'(wr));
        chk({tag, ".regwr"},   32'(RegWrite),   32'(rw));
        chk({tag, ".illegal"}, 32'(Illegal),    32'(il));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},   32'(OutValid),   32'd0);
        chk({tag, ".op"},      32'(ALUControl), 32'd0);
        chk({tag, ".a"},       A,               32'd0);
        chk({tag, ".b"},       B,               32'd0);
        chk({tag, ".wreg"},    32'(WriteReg),   32'd0);
        chk({tag, ".regwr"},   32'(RegWrite),   32'd0);
        chk({tag, ".illegal"}, 32'(Illegal),    32'd0);
    endtask

    initial begin
        Reset_n = 1'b0; InValid = 1'b0; Instruction = '0; RsData = '0; RtData = '0;
        Flush = 1'b0; OutReady = 1'b0;
        tick(); tick();
        chk_zero("reset");
        Reset_n = 1'b1;

        // ori $6,$1,0xF0 captured and held, then async reset mid-stall
        beat(32'h342600F0, 32'h11, 32'h22);
        tick();
        chk_out("ori", 4'd3, 32'h11, 32'hF0, 5'd6, 1'b1, 1'b0);
        InValid = 1'b0;
        #2 Reset_n = 1'b0;
        #1 chk_zero("async_rst");
        tick();
        Reset_n = 1'b1;

        // add $3,$1,$2
        OutReady = 1'b1;
        beat(32'h00221820, 32'd5, 32'd7);
        tick(); chk_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        // addi $4,$1,-1
        beat(32'h2024FFFF, 32'd10, 32'd0);
        tick(); chk_out("addi", 4'd0, 32'd10, 32'hFFFFFFFF, 5'd4, 1'b1, 1'b0);
        // andi $4,$1,0xFFFF
        beat(32'h3024FFFF, 32'd10, 32'd0);
        tick(); chk_out("andi", 4'd2, 32'd10, 32'h0000FFFF, 5'd4, 1'b1, 1'b0);
        // sll $2,$3,4
        beat(32'h00031100, 32'd9, 32'd1);
        tick(); chk_out("sll", 4'd6, 32'd1, 32'd4, 5'd2, 1'b1, 1'b0);
        // lui $5,0x1234
        beat(32'h3C051234, 32'd9, 32'd3);
        tick(); chk_out("lui", 4'd6, 32'h1234, 32'd16, 5'd5, 1'b1, 1'b0);
        // mul $3,$1,$2
        beat(32'h70221802, 32'd6, 32'd7);
        tick(); chk_out("mul", 4'd8, 32'd6, 32'd7, 5'd3, 1'b1, 1'b0);
        // sllv $3,$2,$1 : B = Rs[4:0]
        beat(32'h00221804, 32'h25, 32'hABC);
        tick(); chk_out("sllv", 4'd6, 32'hABC, 32'd5, 5'd3, 1'b1, 1'b0);
        // sw $2,-4($1)
        beat(32'hAC22FFFC, 32'h100, 32'h55);
        tick(); chk_out("sw", 4'd0, 32'h100, 32'hFFFFFFFC, 5'd2, 1'b0, 1'b0);
        // beq $1,$2
        beat(32'h10220003, 32'd8, 32'd9);
        tick(); chk_out("beq", 4'd1, 32'd8, 32'd9, 5'd2, 1'b0, 1'b0);

        // backpressure: sub $8,$1,$2 held for 3 cycles while xor waits
        beat(32'h00224022, 32'd20, 32'd3);
        tick(); chk_out("sub", 4'd1, 32'd20, 32'd3, 5'd8, 1'b1, 1'b0);
        OutReady = 1'b0;
        beat(32'h00224826, 32'hAA, 32'h55);
        #1 chk("bp.inready", 32'(InReady), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("hold", 4'd1, 32'd20, 32'd3, 5'd8, 1'b1, 1'b0);
            chk("hold.inready", 32'(InReady), 32'd0);
        end
        OutReady = 1'b1;
        #1 chk("bp.release", 32'(InReady), 32'd1);
        tick(); chk_out("xor", 4'd5, 32'hAA, 32'h55, 5'd9, 1'b1, 1'b0);

        // flush while holding and with an incoming or-beat
        OutReady = 1'b0;
        beat(32'h00225025, 32'd1, 32'd2);
        Flush = 1'b1;
        tick();
        chk("flush.valid", 32'(OutValid), 32'd0);
        chk("flush.regwr", 32'(RegWrite), 32'd0);
        chk("flush.illegal", 32'(Illegal), 32'd0);
        Flush = 1'b0; InValid = 1'b0;
        tick();
        chk("flush.dropped", 32'(OutValid), 32'd0);

        // illegal opcode still flows
        OutReady = 1'b1;
        beat(32'hFC000000, 32'd1, 32'd2);
        tick(); chk_out("illegal", 4'd0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1);
        // nop
        beat(32'h00000000, 32'd1, 32'd2);
        tick(); chk_out("nop", 4'd6, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0);

        // drain with no new beat
        InValid = 1'b0;
        tick();
        chk("drain.valid", 32'(OutValid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
